// File: rtl/active_list.sv
// In-order retirement tracker for a 2-wide dispatch stage: circular buffer of in-flight
// instructions, single retire/free port, branch-recall tail truncation. Optional AL_RETIRE_CNT_EN.
module active_list #(
    parameter int DEPTH = 32,
    parameter int PTR_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             ext_stall,
    input  logic             valid [2],
    input  logic             uses_rd [2],
    input  logic [5:0]       old_preg [2],
    output logic [PTR_W-1:0] alloc_ptr [2],
    output logic             int_stall,
    input  logic             complete_valid [2],
    input  logic [PTR_W-1:0] complete_ptr [2],
    input  logic             if_recall,
    input  logic [PTR_W-1:0] recalled_tail_ptr,
    output logic             if_freed,
    output logic [5:0]       freed_reg,
    output logic             retired,
    output logic [PTR_W-1:0] retired_ptr,
    output logic [PTR_W-1:0] count,
    output logic [31:0]      retire_count
);

    localparam int IDX_W = $clog2(DEPTH);

    logic [PTR_W-1:0] head;
    logic [PTR_W-1:0] tail;
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] done;
    logic [DEPTH-1:0] busy_nxt;
    logic [DEPTH-1:0] done_nxt;
    logic [DEPTH-1:0] uses_rd_mem;
    logic [5:0]       old_preg_mem [DEPTH];

    logic [PTR_W-1:0] n_ptr;
    logic [PTR_W:0]   need;
    logic             accept;
    logic [IDX_W-1:0] head_idx;
    logic [IDX_W-1:0] alloc_idx [2];
    logic             do_retire;
    logic [PTR_W-1:0] squash_cnt;
    logic [DEPTH-1:0] squash;

    assign count    = tail - head;
    assign head_idx = head[IDX_W-1:0];

    // Dispatch sizing and pointer assignment; outputs are valid even when not accepted.
    assign n_ptr        = PTR_W'(valid[0]) + PTR_W'(valid[1]);
    assign need         = (PTR_W+1)'(count) + (PTR_W+1)'(n_ptr);
    assign int_stall    = (need > (PTR_W+1)'(DEPTH)) || if_recall;
    assign accept       = !ext_stall && !int_stall;
    assign alloc_ptr[0] = tail;
    assign alloc_ptr[1] = tail + PTR_W'(valid[0]);

    always_comb begin
        for (int s = 0; s < 2; s++) begin
            alloc_idx[s] = alloc_ptr[s][IDX_W-1:0];
        end
    end

    assign do_retire = (count != '0) && done[head_idx];

    // Entries in [recalled_tail_ptr, tail) are squashed: offset from the new tail below the squash size.
    assign squash_cnt = tail - recalled_tail_ptr;

    always_comb begin
        squash = '0;
        if (if_recall) begin
            for (int i = 0; i < DEPTH; i++) begin
                squash[i] = {1'b0, IDX_W'(i) - recalled_tail_ptr[IDX_W-1:0]} < squash_cnt;
            end
        end
    end

    // Completion sees the pre-recall busy bits, so the squash below drops completions to
    // squashed entries. Dispatch targets only free entries, so it never collides with the rest.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
        busy_nxt = busy;
        done_nxt = done;
        for (int p = 0; p < 2; p++) begin
            if (complete_valid[p] && busy[complete_ptr[p][IDX_W-1:0]]) begin
                done_nxt[complete_ptr[p][IDX_W-1:0]] = 1'b1;
            end
        end
        if (do_retire) begin
            busy_nxt[head_idx] = 1'b0;
            done_nxt[head_idx] = 1'b0;
        end
        busy_nxt = busy_nxt & ~squash;
        done_nxt = done_nxt & ~squash;
        if (accept) begin
            for (int s = 0; s < 2; s++) begin
                if (valid[s]) begin
                    busy_nxt[alloc_idx[s]] = 1'b1;
                    done_nxt[alloc_idx[s]] = 1'b0;
                end
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            head        <= '0;
            tail        <= '0;
            busy        <= '0;
            done        <= '0;
            retired     <= 1'b0;
            if_freed    <= 1'b0;
            freed_reg   <= '0;
            retired_ptr <= '0;
        end else begin
            busy     <= busy_nxt;
            done     <= done_nxt;
            retired  <= do_retire;
            if_freed <= do_retire && uses_rd_mem[head_idx];
            if (do_retire) begin
                head        <= head + PTR_W'(1);
                freed_reg   <= old_preg_mem[head_idx];
                retired_ptr <= head;
            end
            if (if_recall) begin
                tail <= recalled_tail_ptr;
            end else if (accept) begin
                tail <= tail + n_ptr;
            end
        end
    end

    // NOTE: payload storage is not reset; it is only read for entries that busy/done mark as live.
    always_ff @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (accept && valid[s]) begin
                old_preg_mem[alloc_idx[s]] <= old_preg[s];
                uses_rd_mem[alloc_idx[s]]  <= uses_rd[s];
            end
        end
    end

`ifdef AL_RETIRE_CNT_EN
    logic [31:0] retire_cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt_q <= '0;
        end else if (do_retire) begin
            retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign retire_count = retire_cnt_q;
`else
    assign retire_count = '0;
`endif

endmodule

// File: tb/tb_active_list.sv
// Directed self-checking bench for active_list: reset, in-order retire, full/wrap, recall,
// mid-stream reset and the optional retirement counter.
module tb_active_list;

    localparam int DEPTH = 32;
    localparam int PTR_W = 6;

    logic             clk = 1'b0;
    logic             reset;
    logic             ext_stall;
    logic             valid [2];
    logic             uses_rd [2];
    logic [5:0]       old_preg [2];
    logic [PTR_W-1:0] alloc_ptr [2];
    logic             int_stall;
    logic             complete_valid [2];
    logic [PTR_W-1:0] complete_ptr [2];
    logic             if_recall;
    logic [PTR_W-1:0] recalled_tail_ptr;
    logic             if_freed;
    logic [5:0]       freed_reg;
    logic             retired;
    logic [PTR_W-1:0] retired_ptr;
    logic [PTR_W-1:0] count;
    logic [31:0]      retire_count;

    int checks = 0;
    int errors = 0;

    active_list #(.DEPTH(DEPTH), .PTR_W(PTR_W)) dut (
        .clk               (clk),
        .reset             (reset),
        .ext_stall         (ext_stall),
        .valid             (valid),
        .uses_rd           (uses_rd),
        .old_preg          (old_preg),
        .alloc_ptr         (alloc_ptr),
        .int_stall         (int_stall),
        .complete_valid    (complete_valid),
        .complete_ptr      (complete_ptr),
        .if_recall         (if_recall),
        .recalled_tail_ptr (recalled_tail_ptr),
        .if_freed          (if_freed),
        .freed_reg         (freed_reg),
        .retired           (retired),
        .retired_ptr       (retired_ptr),
        .count             (count),
        .retire_count      (retire_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        ext_stall         = 1'b0;
        if_recall         = 1'b0;
        recalled_tail_ptr = '0;
        for (int s = 0; s < 2; s++) begin
            valid[s]          = 1'b0;
            uses_rd[s]        = 1'b0;
            old_preg[s]       = '0;
            complete_valid[s] = 1'b0;
            complete_ptr[s]   = '0;
        end
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        idle();
        tick();
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        apply_reset();
        #1;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL reset_count: got %0d expected 0", count); end
        checks++; if (int_stall !== 1'b0) begin errors++; $display("FAIL reset_int_stall: got %0b expected 0", int_stall); end
        checks++; if (alloc_ptr[0] !== 6'd0) begin errors++; $display("FAIL reset_alloc0: got %0d expected 0", alloc_ptr[0]); end
        checks++; if (alloc_ptr[1] !== 6'd0) begin errors++; $display("FAIL reset_alloc1: got %0d expected 0", alloc_ptr[1]); end
        checks++; if (if_freed !== 1'b0) begin errors++; $display("FAIL reset_if_freed: got %0b expected 0", if_freed); end
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL reset_retired: got %0b expected 0", retired); end
        checks++; if (freed_reg !== 6'd0) begin errors++; $display("FAIL reset_freed_reg: got %0d expected 0", freed_reg); end
        checks++; if (retired_ptr !== 6'd0) begin errors++; $display("FAIL reset_retired_ptr: got %0d expected 0", retired_ptr); end
        checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL reset_retire_count: got %0d expected 0", retire_count); end
    endtask

    task automatic test_in_order_retire();
        apply_reset();
        valid[0] = 1'b1; valid[1] = 1'b1;
        uses_rd[0] = 1'b1; uses_rd[1] = 1'b0;
        old_preg[0] = 6'd5; old_preg[1] = 6'd9;
        #1;
        checks++; if (alloc_ptr[0] !== 6'd0) begin errors++; $display("FAIL basic_alloc0: got %0d expected 0", alloc_ptr[0]); end
        checks++; if (alloc_ptr[1] !== 6'd1) begin errors++; $display("FAIL basic_alloc1: got %0d expected 1", alloc_ptr[1]); end
        tick();
        idle();
        complete_valid[0] = 1'b1; complete_ptr[0] = 6'd1;
        #1;
        checks++; if (count !== 6'd2) begin errors++; $display("FAIL basic_count: got %0d expected 2", count); end
        tick();
        complete_ptr[0] = 6'd0;
        #1;
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL basic_no_early_retire: got %0b expected 0", retired); end
        tick();
        idle();
        #1;
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL basic_head_not_yet: got %0b expected 0", retired); end
        tick();
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL basic_ret0: got %0b expected 1", retired); end
        checks++; if (retired_ptr !== 6'd0) begin errors++; $display("FAIL basic_ret0_ptr: got %0d expected 0", retired_ptr); end
        checks++; if (if_freed !== 1'b1) begin errors++; $display("FAIL basic_ret0_freed: got %0b expected 1", if_freed); end
        checks++; if (freed_reg !== 6'd5) begin errors++; $display("FAIL basic_ret0_reg: got %0d expected 5", freed_reg); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL basic_ret0_count: got %0d expected 1", count); end
        tick();
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL basic_ret1: got %0b expected 1", retired); end
        checks++; if (retired_ptr !== 6'd1) begin errors++; $display("FAIL basic_ret1_ptr: got %0d expected 1", retired_ptr); end
        checks++; if (if_freed !== 1'b0) begin errors++; $display("FAIL basic_ret1_freed: got %0b expected 0", if_freed); end
        checks++; if (freed_reg !== 6'd9) begin errors++; $display("FAIL basic_ret1_reg: got %0d expected 9", freed_reg); end
        tick();
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL basic_idle_retired: got %0b expected 0", retired); end
        checks++; if (freed_reg !== 6'd9) begin errors++; $display("FAIL basic_hold_reg: got %0d expected 9", freed_reg); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL basic_empty: got %0d expected 0", count); end
    endtask

    task automatic test_ext_stall();
        apply_reset();
        ext_stall = 1'b1;
        valid[0] = 1'b1; valid[1] = 1'b1;
        #1;
        checks++; if (int_stall !== 1'b0) begin errors++; $display("FAIL ext_int_stall: got %0b expected 0", int_stall); end
        tick();
        idle();
        valid[1] = 1'b1;
        #1;
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL ext_no_accept: got %0d expected 0", count); end
        checks++; if (alloc_ptr[1] !== 6'd0) begin errors++; $display("FAIL ext_slot1_alone: got %0d expected 0", alloc_ptr[1]); end
        idle();
    endtask

    task automatic test_full_wrap();
        apply_reset();
        for (int i = 0; i < 16; i++) begin
            valid[0] = 1'b1; valid[1] = 1'b1;
            uses_rd[0] = 1'b1; uses_rd[1] = 1'b1;
            old_preg[0] = 6'(2 * i + 1);
            old_preg[1] = 6'(2 * i + 2);
            tick();
        end
        idle();
        #1;
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_count: got %0d expected 32", count); end
        valid[0] = 1'b1;
        complete_valid[0] = 1'b1; complete_ptr[0] = 6'd0;
        #1;
        checks++; if (int_stall !== 1'b1) begin errors++; $display("FAIL full_stall: got %0b expected 1", int_stall); end
        tick();
        complete_valid[0] = 1'b0;
        #1;
        checks++; if (int_stall !== 1'b1) begin errors++; $display("FAIL full_stall_at_retire: got %0b expected 1", int_stall); end
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL full_count_hold: got %0d expected 32", count); end
        tick();
        checks++; if (retired !== 1'b1) begin errors++; $display("FAIL full_retired: got %0b expected 1", retired); end
        checks++; if (freed_reg !== 6'd1) begin errors++; $display("FAIL full_freed_reg: got %0d expected 1", freed_reg); end
        checks++; if (count !== 6'd31) begin errors++; $display("FAIL full_count31: got %0d expected 31", count); end
        checks++; if (int_stall !== 1'b0) begin errors++; $display("FAIL full_relieved: got %0b expected 0", int_stall); end
        checks++; if (alloc_ptr[0] !== 6'd32) begin errors++; $display("FAIL full_tail_wrap: got %0d expected 32", alloc_ptr[0]); end
        valid[1] = 1'b1;
        #1;
        checks++; if (int_stall !== 1'b1) begin errors++; $display("FAIL c31_two_stall: got %0b expected 1", int_stall); end
        tick();
        idle();
        #1;
        checks++; if (count !== 6'd31) begin errors++; $display("FAIL c31_nothing_written: got %0d expected 31", count); end
        valid[1] = 1'b1; uses_rd[1] = 1'b1; old_preg[1] = 6'd42;
        #1;
        checks++; if (alloc_ptr[1] !== 6'd32) begin errors++; $display("FAIL c31_slot1_ptr: got %0d expected 32", alloc_ptr[1]); end
        checks++; if (int_stall !== 1'b0) begin errors++; $display("FAIL c31_slot1_stall: got %0b expected 0", int_stall); end
        tick();
        idle();
        #1;
        checks++; if (count !== 6'd32) begin errors++; $display("FAIL c31_accepted: got %0d expected 32", count); end
    endtask

    task automatic test_recall();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            valid[0] = 1'b1; valid[1] = 1'b1;
            uses_rd[0] = 1'b1; uses_rd[1] = 1'b1;
            old_preg[0] = 6'(10 + 2 * i);
            old_preg[1] = 6'(11 + 2 * i);
            tick();
        end
        idle();
        #1;
        checks++; if (count !== 6'd6) begin errors++; $display("FAIL recall_pre_count: got %0d expected 6", count); end
        if_recall = 1'b1; recalled_tail_ptr = 6'd3;
        complete_valid[0] = 1'b1; complete_ptr[0] = 6'd4;
        #1;
        checks++; if (int_stall !== 1'b1) begin errors++; $display("FAIL recall_stall: got %0b expected 1", int_stall); end
        tick();
        idle();
        #1;
        checks++; if (count !== 6'd3) begin errors++; $display("FAIL recall_count: got %0d expected 3", count); end
        valid[0] = 1'b1; uses_rd[0] = 1'b1; old_preg[0] = 6'd50;
        #1;
        checks++; if (alloc_ptr[0] !== 6'd3) begin errors++; $display("FAIL recall_next_ptr: got %0d expected 3", alloc_ptr[0]); end
        tick();
        idle();
        complete_valid[0] = 1'b1; complete_ptr[0] = 6'd0;
        complete_valid[1] = 1'b1; complete_ptr[1] = 6'd1;
        #1;
        checks++; if (count !== 6'd4) begin errors++; $display("FAIL recall_redispatch: got %0d expected 4", count); end
        tick();
        complete_ptr[0] = 6'd2;
        complete_valid[1] = 1'b0;
        tick();
        idle();
        checks++; if (retired_ptr !== 6'd0 || retired !== 1'b1) begin errors++; $display("FAIL recall_ret0: got ptr %0d ret %0b expected ptr 0 ret 1", retired_ptr, retired); end
        checks++; if (freed_reg !== 6'd10) begin errors++; $display("FAIL recall_ret0_reg: got %0d expected 10", freed_reg); end
        tick();
        checks++; if (retired_ptr !== 6'd1 || freed_reg !== 6'd11) begin errors++; $display("FAIL recall_ret1: got ptr %0d reg %0d expected ptr 1 reg 11", retired_ptr, freed_reg); end
        tick();
        checks++; if (retired_ptr !== 6'd2 || freed_reg !== 6'd12) begin errors++; $display("FAIL recall_ret2: got ptr %0d reg %0d expected ptr 2 reg 12", retired_ptr, freed_reg); end
        tick();
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL recall_stop: got %0b expected 0", retired); end
        checks++; if (count !== 6'd1) begin errors++; $display("FAIL recall_count1: got %0d expected 1", count); end
        complete_valid[0] = 1'b1; complete_ptr[0] = 6'd3;
        tick();
        idle();
        tick();
        checks++; if (retired_ptr !== 6'd3 || freed_reg !== 6'd50) begin errors++; $display("FAIL recall_ret3: got ptr %0d reg %0d expected ptr 3 reg 50", retired_ptr, freed_reg); end
        tick();
        checks++; if (retired !== 1'b0 || count !== 6'd0) begin errors++; $display("FAIL recall_drained: got ret %0b count %0d expected ret 0 count 0", retired, count); end
    endtask

    task automatic test_reset_mid();
        apply_reset();
        valid[0] = 1'b1; valid[1] = 1'b1;
        uses_rd[0] = 1'b1; uses_rd[1] = 1'b1;
        old_preg[0] = 6'd7; old_preg[1] = 6'd8;
        tick();
        idle();
        complete_valid[0] = 1'b1; complete_ptr[0] = 6'd0;
        tick();
        idle();
        reset = 1'b1;
        if_recall = 1'b1; recalled_tail_ptr = 6'd5;
        tick();
        checks++; if (if_freed !== 1'b0) begin errors++; $display("FAIL midrst_if_freed: got %0b expected 0", if_freed); end
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL midrst_retired: got %0b expected 0", retired); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL midrst_count: got %0d expected 0", count); end
        checks++; if (retire_count !== 32'd0) begin errors++; $display("FAIL midrst_retire_count: got %0d expected 0", retire_count); end
        reset = 1'b0;
        idle();
        tick();
        checks++; if (retired !== 1'b0) begin errors++; $display("FAIL midrst_after: got %0b expected 0", retired); end
    endtask

    task automatic test_retire_count();
        logic [5:0] p;
        logic [31:0] exp_cnt;
        apply_reset();
        p = '0;
        for (int i = 0; i < 20; i++) begin
            valid[0] = 1'b1; valid[1] = 1'b1;
            uses_rd[0] = 1'b1; uses_rd[1] = 1'b1;
            tick();
            idle();
            complete_valid[0] = 1'b1; complete_ptr[0] = p;
            complete_valid[1] = 1'b1; complete_ptr[1] = p + 6'd1;
            tick();
            idle();
            tick();
            tick();
            p = p + 6'd2;
        end
`ifdef AL_RETIRE_CNT_EN
        exp_cnt = 32'd40;
`else
        exp_cnt = 32'd0;
`endif
        checks++; if (retire_count !== exp_cnt) begin errors++; $display("FAIL cnt_value: got %0d expected %0d", retire_count, exp_cnt); end
        checks++; if (retired_ptr !== 6'd39) begin errors++; $display("FAIL cnt_last_ptr: got %0d expected 39", retired_ptr); end
        checks++; if (count !== 6'd0) begin errors++; $display("FAIL cnt_empty: got %0d expected 0", count); end
    endtask

    initial begin
        reset = 1'b1;
        idle();
        test_reset();
        test_in_order_retire();
        test_ext_stall();
        test_full_wrap();
        test_recall();
        test_reset_mid();
        test_retire_count();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1);
    end

endmodule
